prog_fetch: RTL and testbench
=============================

Name: prog_fetch

Overview:
Instruction-fetch sequencer that sits directly upstream of the processor control unit. It reads 9-bit words from a synchronous program ROM and presents each instruction on DIN with Run asserted. When the instruction is mvi, it also supplies the immediate word in the following cycle. It then waits for the processor's Done before fetching the next word. It owns the program counter and detects a HALT sentinel word.

Parameters:
ADDR_W, 5, ROM address width; pc wraps modulo 2^ADDR_W
HALT_WORD, 9'h1FF, instruction word that stops fetching; this word is never issued to the processor

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous, active-low reset
Enable  in  1  level; 1 = fetch and issue instructions
IR_in  in  1  from control unit; high while the processor sits in T0 ready to load IR
Done  in  1  from control unit; instruction complete this cycle
mem_addr  out  ADDR_W  ROM address; ROM returns data 1 cycle after the address is presented at a clock edge
mem_rdata  in  9  ROM read data
DIN  out  9  processor data input: instruction word, then immediate
Run  out  1  instruction valid on DIN
Halted  out  1  HALT_WORD fetched; sequencer stopped
pc  out  ADDR_W  address of the next word to fetch
retired  out  8  count of instructions completed; wraps 255 -> 0

Behaviour:
- Reset values (asynchronous): state IDLE, pc=0, ir_q=0, Run=0, DIN=0, mem_addr=0, Halted=0, retired=0. Reset mid-instruction abandons it immediately, with no partial pc update.
- Opcode is DIN[8:6]. mvi = 3'b001; every other opcode is a single-word instruction.
- Acceptance: a rising edge where Run=1 and IR_in=1.
- States and transitions:
  - IDLE: Run=0, DIN=0, mem_addr=pc. Enable=1 -> FETCH.
  - FETCH: mem_addr=pc -> LATCH.
  - LATCH: mem_addr=pc; ir_q <= mem_rdata. If mem_rdata==HALT_WORD -> HALT; else -> ISSUE.
  - ISSUE: DIN=ir_q, Run=1, mem_addr=pc+1 (prefetch).
    - Holds indefinitely until acceptance.
    - On acceptance: pc <= pc+1; if ir_q[8:6]==mvi -> IMM, else -> EXEC.
  - IMM: exactly 1 cycle. DIN=mem_rdata (the word at the old pc+1), Run=0. pc <= pc+1 (the immediate is consumed).
    - If Done=1 this cycle: retired++ and -> FETCH (Enable=1) or IDLE (Enable=0).
    - If Done=0: -> EXEC.
  - EXEC: DIN=0, Run=0, mem_addr=pc. Waits for Done=1; then retired++ and -> FETCH (Enable=1) or IDLE (Enable=0).
  - HALT: Halted=1, Run=0, DIN=0. Left only by reset.
- Latency:
  - IDLE with Enable rising: Run goes high on the 3rd edge (IDLE->FETCH->LATCH->ISSUE).
  - Done to next Run: 3 cycles.
- Enable deasserted mid-instruction: the current instruction completes, then the block returns to IDLE. pc still points to the next unfetched word.
- Done outside IMM/EXEC is ignored (no retire, no transition).
- pc arithmetic is modulo 2^ADDR_W. An mvi at the last address takes its immediate from address 0 and leaves pc=1.
- Run is never high in any state other than ISSUE. DIN changes only on state change.

Test Plan:
1. Reset, then ROM[0]=mv R1,R2 (9'b000_001_010), ROM[1]=HALT_WORD, Enable=1, control unit model in loop -> Run high on the 3rd edge with DIN=9'h00A. After Done: retired=1, Halted=1, pc=1.
2. ROM[0]=mvi R0 (9'h040), ROM[1]=9'h005, ROM[2]=HALT -> DIN=9'h040 in the acceptance cycle. In the next cycle DIN=9'h005 while Done=1. Final pc=2, retired=1.
3. add instruction, with IR_in held low for 4 cycles in ISSUE -> Run and DIN stable for all 4 cycles, no pc change. Accepted on IR_in rise. Done 2 cycles later (T3) -> retired increments once.
4. ADDR_W=2, ROM[3]=mvi, ROM[0]=9'h0AA -> immediate 9'h0AA is delivered and pc wraps to 1.
5. Enable dropped during EXEC of an add -> Done is honoured, retired increments, the state returns to IDLE, and Run stays 0. Re-enabling resumes at the saved pc.
6. Resetn pulsed low in ISSUE -> on the same cycle Run=0, DIN=0, pc=0, and all outputs return to their reset values. Restart then refetches ROM[0].

Source files
------------

// File: rtl/prog_fetch.sv
// prog_fetch: instruction-fetch sequencer feeding the control unit from a synchronous program ROM
module prog_fetch #(
    parameter int ADDR_W = 5,
    parameter logic [8:0] HALT_WORD = 9'h1FF
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Enable,
    input  logic              IR_in,
    input  logic              Done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [8:0]        mem_rdata,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic              Halted,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        retired
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, IMM, EXEC, HALT} state_t;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [ADDR_W-1:0] PC_ONE = 1;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [8:0] ir_q, ir_d;
    logic [7:0] retired_q, retired_d;
    // state, program counter, instruction and retire counter registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end
    // next-state logic; outputs decode from state so reset clears them at once
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        mem_addr  = pc_q;
        DIN       = '0;
        Run       = 1'b0;
        Halted    = 1'b0;
        case (state_q)
            IDLE:  state_d = Enable ? FETCH : IDLE;
            FETCH: state_d = LATCH;
            LATCH: begin
                ir_d    = mem_rdata;
                state_d = (mem_rdata == HALT_WORD) ? HALT : ISSUE;
            end
            ISSUE: begin
                DIN      = ir_q;
                Run      = 1'b1;
                mem_addr = pc_q + PC_ONE;
                if (IR_in) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = (ir_q[8:6] == OP_MVI) ? IMM : EXEC;
                end
            end
            IMM: begin
                DIN  = mem_rdata;
                pc_d = pc_q + PC_ONE;
                if (Done) begin
                    retired_d = retired_q + 8'd1;
                    state_d   = Enable ? FETCH : IDLE;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (Done) begin
                    retired_d = retired_q + 8'd1;
                    state_d   = Enable ? FETCH : IDLE;
                end
            end
            HALT:    Halted = 1'b1;
            default: state_d = IDLE;
        endcase
    end
    assign pc      = pc_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_prog_fetch.sv
// tb_prog_fetch: directed and randomized checks of prog_fetch against a behavioural model
module tb_prog_fetch;
    logic Clock = 0, Resetn = 1, Enable = 0, IR_in = 0, Done = 0;
    logic [4:0] mem_addr, pc;
    logic [8:0] mem_rdata = '0, DIN;
    logic Run, Halted;
    logic [7:0] retired;
    logic [8:0] rom [32];
    int checks = 0, errors = 0;
    bit armed = 0;
    // model of the sequencer: cursor, retire count and what it is doing now
    int m_pc, m_ret, m_cnt;
    bit m_halt, m_iss, m_imm, m_wait;
    logic [8:0] m_ir, e_din;
    int e_addr;

    prog_fetch dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .IR_in(IR_in), .Done(Done),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .DIN(DIN), .Run(Run),
        .Halted(Halted), .pc(pc), .retired(retired)
    );

    always #5 Clock = ~Clock;
    // synchronous ROM: data one cycle after the address edge
    always @(posedge Clock) mem_rdata <= rom[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic finish_instr();
        m_ret = (m_ret + 1) % 256;
        m_wait = 0;
        m_cnt = Enable ? 2 : 0;
    endtask

    task automatic model_step();
        if (m_halt) begin
        end else if (m_iss) begin
            if (IR_in) begin
                m_pc = (m_pc + 1) % 32;
                m_iss = 0;
                if (m_ir[8:6] == 3'b001) m_imm = 1; else m_wait = 1;
            end
        end else if (m_imm) begin
            m_imm = 0;
            m_pc = (m_pc + 1) % 32;
            if (Done) finish_instr(); else m_wait = 1;
        end else if (m_wait) begin
            if (Done) finish_instr();
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                if (rom[m_pc] == 9'h1FF) m_halt = 1;
                else begin m_iss = 1; m_ir = rom[m_pc]; end
            end
        end else if (Enable) m_cnt = 2;
    endtask

    // every cycle: advance the model and compare all outputs
    always @(posedge Clock) begin
        if (!Resetn) begin
            m_pc = 0; m_ret = 0; m_cnt = 0; m_halt = 0; m_iss = 0; m_imm = 0; m_wait = 0; m_ir = 0;
        end else model_step();
        #1;
        if (Resetn && armed) begin
            e_din = m_iss ? m_ir : (m_imm ? rom[m_pc] : 9'h000);
            e_addr = m_iss ? (m_pc + 1) % 32 : m_pc;
            chk("run", Run, m_iss);
            chk("din", DIN, e_din);
            chk("mem_addr", mem_addr, e_addr);
            chk("pc", pc, m_pc);
            chk("halted", Halted, m_halt);
            chk("retired", retired, m_ret);
        end
    end

    task automatic do_reset();
        Resetn = 0; IR_in = 0; Done = 0;
        #1;
        chk("rst_run", Run, 0);
        chk("rst_din", DIN, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_retired", retired, 0);
        armed = 1;
        step(2);
        Resetn = 1;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!Run && n < 20) begin step(1); n++; end
        chk("run_seen", Run, 1);
    endtask

    task automatic fill(input logic [8:0] w);
        for (int i = 0; i < 32; i++) rom[i] = w;
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w;
        fill(9'h1FF);
        @(negedge Clock);
        // single-word instruction then HALT
        rom[0] = 9'b000_001_010; rom[1] = 9'h1FF;
        Enable = 0; do_reset(); Enable = 1;
        step(2); chk("t1_run_early", Run, 0);
        step(1); chk("t1_run", Run, 1); chk("t1_din", DIN, 9'h00A);
        IR_in = 1; step(1); IR_in = 0; Done = 1; step(1); Done = 0;
        step(4);
        chk("t1_retired", retired, 1); chk("t1_halted", Halted, 1); chk("t1_pc", pc, 1);
        // mvi with immediate, Done in the immediate cycle
        rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h1FF;
        Enable = 0; do_reset(); Enable = 1;
        step(3); chk("t2_din", DIN, 9'h040);
        IR_in = 1; step(1); IR_in = 0;
        chk("t2_imm", DIN, 9'h005); chk("t2_imm_run", Run, 0);
        Done = 1; step(1); Done = 0; step(5);
        chk("t2_pc", pc, 2); chk("t2_retired", retired, 1); chk("t2_halted", Halted, 1);
        // add stalled in ISSUE for four cycles
        rom[0] = 9'h081; rom[1] = 9'h1FF;
        Enable = 0; do_reset(); Enable = 1;
        wait_run();
        for (int i = 0; i < 4; i++) begin
            step(1); chk("t3_hold_run", Run, 1); chk("t3_hold_din", DIN, 9'h081); chk("t3_hold_pc", pc, 0);
        end
        IR_in = 1; step(1); IR_in = 0; chk("t3_pc", pc, 1);
        step(1); Done = 1; step(1); Done = 0;
        chk("t3_retired", retired, 1);
        // mvi at the last address wraps to address 0 for its immediate
        fill(9'h000); rom[0] = 9'h0AA; rom[31] = 9'h040;
        Enable = 0; do_reset(); Enable = 1;
        for (int i = 0; i < 31; i++) begin
            wait_run(); IR_in = 1; step(1); IR_in = 0; Done = 1; step(1); Done = 0;
        end
        wait_run(); chk("t4_din", DIN, 9'h040); chk("t4_pc", pc, 31);
        IR_in = 1; step(1); IR_in = 0;
        chk("t4_imm", DIN, 9'h0AA); chk("t4_pc_imm", pc, 0);
        Done = 1; step(1); Done = 0;
        chk("t4_pc_after", pc, 1); chk("t4_retired", retired, 32);
        // Enable dropped during EXEC, then resumed
        fill(9'h1FF); rom[0] = 9'h081; rom[1] = 9'h0C3;
        Enable = 0; do_reset(); Enable = 1;
        wait_run(); IR_in = 1; step(1); IR_in = 0; Enable = 0;
        step(2); Done = 1; step(1); Done = 0;
        chk("t5_retired", retired, 1); chk("t5_pc", pc, 1);
        for (int i = 0; i < 4; i++) begin step(1); chk("t5_idle_run", Run, 0); end
        Enable = 1; step(3);
        chk("t5_run", Run, 1); chk("t5_din", DIN, 9'h0C3);
        // reset pulsed mid-ISSUE, then refetch from address 0
        #2; do_reset();
        step(3); chk("t6_run", Run, 1); chk("t6_din", DIN, 9'h081);
        // randomized epochs; later ones contain a HALT word
        for (int e = 0; e < 3; e++) begin
            for (int i = 0; i < 32; i++) begin
                w = 9'($urandom_range(0, 510));
                rom[i] = w;
            end
            if (e > 0) rom[$urandom_range(8, 31)] = 9'h1FF;
            Enable = 0; do_reset();
            for (int c = 0; c < (e == 0 ? 4000 : 1000); c++) begin
                Enable = ($urandom_range(0, 19) != 0);
                IR_in = 1'($urandom_range(0, 1));
                Done = ($urandom_range(0, 2) == 0);
                if (e > 0 && $urandom_range(0, 799) == 0) do_reset();
                step(1);
            end
        end
        IR_in = 0; Done = 0; Enable = 0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
